store_commit_buffer: RTL and testbench

Post-commit store queue between the reorder buffer's memory-write commit port and the data cache. Each store retired by the reorder buffer is captured in one cycle. The queue drains stores to the cache in program order through a valid/ready request plus completion handshake. Back-pressure goes to the reorder buffer through a stall signal, and younger loads see committed-but-undrained stores through an address-match lookup.

---
 rtl/mips_core_pkg.sv | 30 +++
 rtl/scb_addr_match.sv | 67 ++++++
 rtl/store_commit_buffer.sv | 158 +++++++++++++++
 tb/tb_store_commit_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared types and constants for the store commit buffer.
//   scb_entry_t  - one buffered store {addr, data}
//   scb_state_t  - drain FSM states
//   SCB_DEPTH    - default buffer depth
// Default widths come from the ADDR_WIDTH / DATA_WIDTH macros (32 if unset).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

    localparam int SCB_DEPTH      = 4;
    localparam int SCB_ADDR_WIDTH = `ADDR_WIDTH;
    localparam int SCB_DATA_WIDTH = `DATA_WIDTH;

    typedef struct packed {
        logic [SCB_ADDR_WIDTH-1:0] addr;
        logic [SCB_DATA_WIDTH-1:0] data;
    } scb_entry_t;

    typedef enum logic [1:0] {
        SCB_IDLE,
        SCB_ISSUE,
        SCB_WAIT
    } scb_state_t;

endpackage

// File: rtl/scb_addr_match.sv
// scb_addr_match: load lookup against the live entries of the store buffer.
//   ld_word     in   word address of the issuing load
//   entry_word  in   word address of every slot
//   entry_data  in   data of every slot (STORE_FWD_EN builds only)
//   wr_idx      in   write slot index (STORE_FWD_EN builds only)
//   rd_idx      in   head slot index
//   count       in   number of live entries
//   match       out  some live entry has the load's word address
//   fwd_data    out  youngest matching entry's data, or 0
// Macro STORE_FWD_EN enables the youngest-match data select; without it
// only the OR of all matches is produced and fwd_data is 0.
module scb_addr_match #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int PTR_W     = IDX_W + 1
) (
    input  logic [WORD_WIDTH-1:0]             ld_word,
    input  logic [DEPTH-1:0][WORD_WIDTH-1:0]  entry_word,
`ifdef STORE_FWD_EN
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  entry_data,
    input  logic [IDX_W-1:0]                  wr_idx,
`endif
    input  logic [IDX_W-1:0]                  rd_idx,
    input  logic [PTR_W-1:0]                  count,
    output logic                              match,
    output logic [DATA_WIDTH-1:0]             fwd_data
);

    logic [DEPTH-1:0] hit;

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        logic [IDX_W-1:0] age;
        hit = '0;
        age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age    = IDX_W'(i) - rd_idx;
            hit[i] = ({1'b0, age} < count) && (entry_word[i] == ld_word);
        end
    end

    assign match = |hit;

`ifdef STORE_FWD_EN
    // Walk from the newest slot (wr_idx-1) toward older ones; the modular
    // index subtraction handles wrap-around, and non-live slots never hit.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             found;
        fwd_data = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_idx - IDX_W'(k + 1);
            if (!found && hit[idx]) begin
                found    = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end
`else
    assign fwd_data = '0;
`endif

endmodule

// File: rtl/store_commit_buffer.sv
// store_commit_buffer: post-commit store queue between the ROB commit port
// and the data cache. Stores drain in program order; loads look up
// committed-but-undrained stores by word address.
//   clk, rst_n                    clock, async active-low reset
//   cm_wr_en/addr/data      in    store committed by the ROB
//   st_stall                out   buffer full, ROB holds its head store
//   mem_req_valid/addr/data out   head store presented to the cache
//   mem_req_ready           in    cache accepts the request
//   mem_done                in    cache finished the accepted write
//   ld_addr                 in    address of the issuing load
//   ld_match / ld_fwd_data  out   lookup result (see scb_addr_match)
//   empty                   out   nothing held, nothing outstanding
// Macro STORE_FWD_EN: ld_fwd_data carries the youngest match's data;
// when undefined it is 0 and ld_match only tells the load to wait.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_commit_buffer
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = SCB_DEPTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cm_wr_en,
    input  logic [ADDR_WIDTH-1:0] cm_wr_addr,
    input  logic [DATA_WIDTH-1:0] cm_wr_data,
    output logic                  st_stall,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_req_ready,
    input  logic                  mem_done,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_match,
    output logic [DATA_WIDTH-1:0] ld_fwd_data,
    output logic                  empty
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int WORD_W = ADDR_WIDTH - 2;

    logic [PTR_W-1:0]                  rd_ptr;
    logic [PTR_W-1:0]                  wr_ptr;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]  addr_mem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  data_mem;
    logic [DEPTH-1:0][WORD_W-1:0]      entry_word;
    scb_state_t                        state;
    scb_state_t                        state_nxt;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [PTR_W-1:0] count;
    logic             ptr_eq;
    logic             full;
    logic             push;
    logic             pop;

    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign ptr_eq = (rd_ptr == wr_ptr);
    assign full   = (rd_idx == wr_idx) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

    // Full is judged on registered pointers only, so a pop in the same
    // cycle does not open a slot until the next cycle.
    assign push = cm_wr_en && !full;
    assign pop  = (state == SCB_WAIT) && mem_done;

    // NOTE: the entry array sits on the async reset because the reset state
    // is all-zero entries, which mem_req_addr/mem_req_data expose directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            addr_mem <= '0;
            data_mem <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            if (push) begin
                addr_mem[wr_idx] <= cm_wr_addr;
                data_mem[wr_idx] <= cm_wr_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        unique case (state)
            // Entering ISSUE on the push edge gives valid one cycle later.
            SCB_IDLE:  if (!ptr_eq || push) state_nxt = SCB_ISSUE;
            SCB_ISSUE: if (mem_req_ready) state_nxt = SCB_WAIT;
            // After popping the head, anything left (or arriving) is next.
            SCB_WAIT:  if (mem_done) begin
                state_nxt = (count > PTR_W'(1) || push) ? SCB_ISSUE : SCB_IDLE;
            end
            default:   state_nxt = SCB_IDLE;
        endcase
    end

    // The head slot is held until popped, so the request stays stable.
    assign st_stall      = full;
    assign mem_req_valid = (state == SCB_ISSUE);
    assign mem_req_addr  = addr_mem[rd_idx];
    assign mem_req_data  = data_mem[rd_idx];
    assign empty         = ptr_eq;

    always_comb begin
        entry_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_word[i] = addr_mem[i][ADDR_WIDTH-1:2];
        end
    end

    // Byte offset within the word plays no part in the lookup.
    logic unused_ld_offset;
    assign unused_ld_offset = ^ld_addr[1:0];

    scb_addr_match #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_addr_match (
        .ld_word    (ld_addr[ADDR_WIDTH-1:2]),
        .entry_word (entry_word),
`ifdef STORE_FWD_EN
        .entry_data (data_mem),
        .wr_idx     (wr_idx),
`endif
        .rd_idx     (rd_idx),
        .count      (count),
        .match      (ld_match),
        .fwd_data   (ld_fwd_data)
    );

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb_store_commit_buffer: self-checking bench for store_commit_buffer.
// Cycle table for single store and forwarding, hand sequences for fill,
// same-cycle push/pop and async reset, and a randomized ordering run
// against a queue model. Expected forwarding data follows STORE_FWD_EN.
module tb_store_commit_buffer;
    import mips_core_pkg::*;

    localparam int AW = SCB_ADDR_WIDTH;
    localparam int DW = SCB_DATA_WIDTH;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cm_wr_en;
    logic [AW-1:0] cm_wr_addr;
    logic [DW-1:0] cm_wr_data;
    logic          st_stall;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic          mem_req_ready;
    logic          mem_done;
    logic [AW-1:0] ld_addr;
    logic          ld_match;
    logic [DW-1:0] ld_fwd_data;
    logic          empty;

    store_commit_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cm_wr_en      (cm_wr_en),
        .cm_wr_addr    (cm_wr_addr),
        .cm_wr_data    (cm_wr_data),
        .st_stall      (st_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .mem_done      (mem_done),
        .ld_addr       (ld_addr),
        .ld_match      (ld_match),
        .ld_fwd_data   (ld_fwd_data),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fx(input logic [DW-1:0] d);
        return FWD ? d : '0;
    endfunction

    // ---------------- table-driven cycle vectors ----------------
    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          ready;
        logic          done;
        logic [AW-1:0] ld;
        logic          e_stall;
        logic          e_valid;
        logic [AW-1:0] e_req_addr;
        logic [DW-1:0] e_req_data;
        logic          e_empty;
        logic          e_match;
        logic [DW-1:0] e_fwd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic rdy, input logic dn, input logic [AW-1:0] la,
                                input logic st, input logic vl, input logic [AW-1:0] ra,
                                input logic [DW-1:0] rd, input logic em, input logic mt,
                                input logic [DW-1:0] fw);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.ready = rdy; v.done = dn; v.ld = la;
        v.e_stall = st; v.e_valid = vl; v.e_req_addr = ra; v.e_req_data = rd;
        v.e_empty = em; v.e_match = mt; v.e_fwd = fw;
        return v;
    endfunction

    // ---------------- behavioural model for the random run ----------------
    scb_entry_t q[$];

    function automatic void model_lookup(input logic [AW-1:0] a, output logic m, output logic [DW-1:0] d);
        m = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!m && q[i].addr[AW-1:2] == a[AW-1:2]) begin
                m = 1'b1;
                d = q[i].data;
            end
        end
        if (!FWD) d = '0;
    endfunction

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cm_wr_en = 1'b1; cm_wr_addr = a; cm_wr_data = d;
        tick();
        cm_wr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        mem_req_ready = 1'b1; mem_done = 1'b1;
        while (!empty && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", empty, 1);
        mem_req_ready = 1'b0; mem_done = 1'b0;
    endtask

    task automatic serve_one(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        mem_req_ready = 1'b1;
        #1;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, mem_req_valid, 1);
        check({name, "_addr"}, mem_req_addr, a);
        check({name, "_data"}, mem_req_data, d);
        tick();
        mem_req_ready = 1'b0; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        logic          m_exp;
        logic [DW-1:0] d_exp;
        logic [DW-1:0] sent_data[10];
        int   n_sent, n_acc, n_done, cyc;
        bit   outstanding, exp_valid, do_push, do_acc, do_pop;

        rst_n = 1'b0; cm_wr_en = 1'b0; cm_wr_addr = '0; cm_wr_data = '0;
        mem_req_ready = 1'b0; mem_done = 1'b0; ld_addr = '0;
        #2;
        check("rst_stall", st_stall, 0);
        check("rst_valid", mem_req_valid, 0);
        check("rst_match", ld_match, 0);
        check("rst_fwd", ld_fwd_data, 0);
        check("rst_empty", empty, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // --- single store, then forwarding (each row: drive, check, clock) ---
        vt[0]  = mk(0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0);
        vt[1]  = mk(1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 32'h102, 0, 1, 32'h100, 32'hDEADBEEF, 0, 1, fx(32'hDEADBEEF));
        vt[3]  = mk(0, 0, 0, 1, 0, 32'h100, 0, 1, 32'h100, 32'hDEADBEEF, 0, 1, fx(32'hDEADBEEF));
        vt[4]  = mk(0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0, 1, fx(32'hDEADBEEF));
        vt[5]  = mk(0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, fx(32'hDEADBEEF));
        vt[6]  = mk(0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0);
        vt[7]  = mk(1, 32'h40, 32'h11, 0, 0, 32'h40, 0, 0, 0, 0, 1, 0, 0);
        vt[8]  = mk(1, 32'h40, 32'h22, 0, 0, 32'h40, 0, 1, 32'h40, 32'h11, 0, 1, fx(32'h11));
        vt[9]  = mk(0, 0, 0, 0, 0, 32'h42, 0, 1, 32'h40, 32'h11, 0, 1, fx(32'h22));
        vt[10] = mk(0, 0, 0, 0, 0, 32'h44, 0, 1, 32'h40, 32'h11, 0, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 32'h3C, 0, 1, 32'h40, 32'h11, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cm_wr_en = vt[i].wr_en; cm_wr_addr = vt[i].wr_addr; cm_wr_data = vt[i].wr_data;
            mem_req_ready = vt[i].ready; mem_done = vt[i].done; ld_addr = vt[i].ld;
            #1;
            check($sformatf("vec%0d_stall", i), st_stall, vt[i].e_stall);
            check($sformatf("vec%0d_valid", i), mem_req_valid, vt[i].e_valid);
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d_req_addr", i), mem_req_addr, vt[i].e_req_addr);
                check($sformatf("vec%0d_req_data", i), mem_req_data, vt[i].e_req_data);
            end
            check($sformatf("vec%0d_empty", i), empty, vt[i].e_empty);
            check($sformatf("vec%0d_match", i), ld_match, vt[i].e_match);
            check($sformatf("vec%0d_fwd", i), ld_fwd_data, vt[i].e_fwd);
            tick();
        end
        cm_wr_en = 1'b0;
        drain();

        // --- fill to full, 5th push held off until a pop ---
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(i * 4), 32'hA0 + 32'(i));
        check("fill_stall", st_stall, 1);
        cm_wr_en = 1'b1; cm_wr_addr = 32'h210; cm_wr_data = 32'hA4; ld_addr = 32'h210;
        tick();
        check("fill_5th_stall", st_stall, 1);
        check("fill_5th_ignored", ld_match, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("fill_pop_unstall", st_stall, 0);
        check("fill_5th_still_out", ld_match, 0);
        check("fill_next_head", mem_req_addr, 32'h204);
        tick();
        cm_wr_en = 1'b0;
        #1;
        check("fill_5th_stall_again", st_stall, 1);
        check("fill_5th_match", ld_match, 1);
        check("fill_5th_fwd", ld_fwd_data, fx(32'hA4));
        serve_one("fill_d1", 32'h204, 32'hA1);
        serve_one("fill_d2", 32'h208, 32'hA2);
        serve_one("fill_d3", 32'h20C, 32'hA3);
        serve_one("fill_d4", 32'h210, 32'hA4);
        #1;
        check("fill_empty", empty, 1);

        // --- push in the same cycle as mem_done with 2 held ---
        push_one(32'h300, 32'hB0);
        push_one(32'h304, 32'hB1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("sim_in_wait", mem_req_valid, 0);
        cm_wr_en = 1'b1; cm_wr_addr = 32'h308; cm_wr_data = 32'hB2; mem_done = 1'b1;
        tick();
        cm_wr_en = 1'b0; mem_done = 1'b0; ld_addr = 32'h300;
        #1;
        check("sim_issue", mem_req_valid, 1);
        check("sim_head_addr", mem_req_addr, 32'h304);
        check("sim_head_data", mem_req_data, 32'hB1);
        check("sim_old_gone", ld_match, 0);
        ld_addr = 32'h308;
        #1;
        check("sim_new_in", ld_match, 1);
        check("sim_stall", st_stall, 0);
        push_one(32'h30C, 32'hB3);
        check("sim_count3_stall", st_stall, 0);
        push_one(32'h310, 32'hB4);
        check("sim_count4_stall", st_stall, 1);
        drain();

        // --- async reset while waiting on the cache with 3 held ---
        push_one(32'h400, 32'hC0);
        push_one(32'h404, 32'hC1);
        push_one(32'h408, 32'hC2);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; ld_addr = 32'h404;
        #1;
        check("ar_wait_valid", mem_req_valid, 0);
        check("ar_pre_match", ld_match, 1);
        rst_n = 1'b0;
        #1;
        check("ar_stall", st_stall, 0);
        check("ar_valid", mem_req_valid, 0);
        check("ar_match", ld_match, 0);
        check("ar_fwd", ld_fwd_data, 0);
        check("ar_empty", empty, 1);
        check("ar_req_addr", mem_req_addr, 0);
        check("ar_req_data", mem_req_data, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_after_empty", empty, 1);
        check("ar_after_valid", mem_req_valid, 0);

        // --- randomized ordering across wrap, checked against queue model ---
        q.delete();
        n_sent = 0; n_acc = 0; n_done = 0; cyc = 0; outstanding = 0;
        while (n_done < 10 && cyc < 3000) begin
            cm_wr_en      = (n_sent < 10) && ($urandom_range(0, 2) != 0);
            cm_wr_addr    = 32'(n_sent * 4);
            cm_wr_data    = $urandom;
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_done      = outstanding && ($urandom_range(0, 2) == 0);
            ld_addr       = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
            #1;
            exp_valid = (q.size() > 0) && !outstanding;
            model_lookup(ld_addr, m_exp, d_exp);
            check("rnd_stall", st_stall, q.size() == 4);
            check("rnd_valid", mem_req_valid, exp_valid);
            check("rnd_empty", empty, q.size() == 0);
            check("rnd_match", ld_match, m_exp);
            check("rnd_fwd", ld_fwd_data, d_exp);
            do_push = cm_wr_en && (q.size() < 4);
            do_acc  = exp_valid && mem_req_ready;
            do_pop  = outstanding && mem_done;
            if (do_acc) begin
                check("rnd_order_addr", mem_req_addr, 32'(n_acc * 4));
                check("rnd_order_data", mem_req_data, sent_data[n_acc]);
                n_acc++;
            end
            tick();
            cyc++;
            if (do_pop) begin
                void'(q.pop_front());
                outstanding = 0;
                n_done++;
            end
            if (do_acc) outstanding = 1;
            if (do_push) begin
                q.push_back('{addr: cm_wr_addr, data: cm_wr_data});
                sent_data[n_sent] = cm_wr_data;
                n_sent++;
            end
        end
        cm_wr_en = 1'b0; mem_req_ready = 1'b0; mem_done = 1'b0;
        check("rnd_all_drained", n_done, 10);
        #1;
        check("rnd_final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
